iq_mod: RTL and testbench

Quadrature up-converter for the transmit path: consumes signed baseband I/Q samples through a valid/ready handshake and mixes them onto an internal 4-phase LO. The LO uses cos = +1, 0, −1, 0 and sin = 0, +1, 0, −1, with each phase held DIV clocks. The block produces s = I·cos − Q·sin for the DAC/serializer stage. It is the transmit-side counterpart of the demodulator's quadrature generator and uses the same phase sequence and phase hold.

---
 rtl/iq_mod.sv | 139 +++++++++++++
 tb/tb_iq_mod.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_mod.sv
// Quadrature up-converter: mixes buffered signed I/Q samples onto a 4-phase LO
// (cos = +1,0,-1,0; sin = 0,+1,0,-1), one sample per 4*DIV clock carrier period.
module iq_mod #(
   parameter int unsigned W   = 8,
   parameter int unsigned DIV = 5
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                enable,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [W-1:0] in_i,
   input  logic signed [W-1:0] in_q,
   output logic                out_valid,
   output logic signed [W:0]   out_data,
   output logic [1:0]          lo_phase,
   output logic                underrun
);

   localparam int unsigned    CntW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e                state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [1:0]            p_q, p_d;
   logic                  pend_valid_q, pend_valid_d;
   logic signed [W-1:0]   pend_i_q, pend_i_d, pend_q_q, pend_q_d;
   logic                  cur_valid_q, cur_valid_d;
   logic signed [W-1:0]   cur_i_q, cur_i_d, cur_q_q, cur_q_d;
   logic                  underrun_q, underrun_d;
   logic                  boundary, accept, load;
   logic signed [W:0]     ext_i, ext_q, mix;

   assign accept   = in_valid & ~pend_valid_q;
   assign boundary = (state_q == StRun) & (cnt_q == CntMax) & (p_q == 2'd3);
   // pend is loaded either at startup from IDLE or at a period boundary while enabled.
   assign load     = enable & pend_valid_q & ((state_q == StIdle) | boundary);

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= StIdle;
      else         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (enable & pend_valid_q) state_d = StRun;
         StRun:   if (boundary & ~enable)    state_d = StDrain;
         StDrain: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Datapath next-state: LO counters, input buffer, current sample
   always_comb begin
      cnt_d        = '0;
      p_d          = '0;
      pend_valid_d = pend_valid_q;
      pend_i_d     = pend_i_q;
      pend_q_d     = pend_q_q;
      cur_valid_d  = cur_valid_q;
      cur_i_d      = cur_i_q;
      cur_q_d      = cur_q_q;
      underrun_d   = boundary & enable & ~pend_valid_q;

      if (state_q == StRun) begin
         if (cnt_q == CntMax) begin
            p_d = p_q + 2'd1;
         end else begin
            cnt_d = cnt_q + CntW'(1);
            p_d   = p_q;
         end
      end

      if (load) begin
         pend_valid_d = 1'b0;
      end else if (accept) begin
         pend_valid_d = 1'b1;
         pend_i_d     = in_i;
         pend_q_d     = in_q;
      end

      if (load) begin
         cur_valid_d = 1'b1;
         cur_i_d     = pend_i_q;
         cur_q_d     = pend_q_q;
      end else if (boundary | (state_q != StRun)) begin
         cur_valid_d = 1'b0;
         cur_i_d     = '0;
         cur_q_d     = '0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q        <= '0;
         p_q          <= '0;
         pend_valid_q <= 1'b0;
         pend_i_q     <= '0;
         pend_q_q     <= '0;
         cur_valid_q  <= 1'b0;
         cur_i_q      <= '0;
         cur_q_q      <= '0;
         underrun_q   <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         p_q          <= p_d;
         pend_valid_q <= pend_valid_d;
         pend_i_q     <= pend_i_d;
         pend_q_q     <= pend_q_d;
         cur_valid_q  <= cur_valid_d;
         cur_i_q      <= cur_i_d;
         cur_q_q      <= cur_q_d;
         underrun_q   <= underrun_d;
      end
   end

   // Outputs: mixer decode on registered state only; W+1 bits hold -(-2^(W-1)).
   always_comb begin
      ext_i = {cur_i_q[W-1], cur_i_q};
      ext_q = {cur_q_q[W-1], cur_q_q};
      unique case (p_q)
         2'd0:    mix = ext_i;
         2'd1:    mix = -ext_q;
         2'd2:    mix = -ext_i;
         default: mix = ext_q;
      endcase
      out_valid = (state_q == StRun) & cur_valid_q;
      out_data  = out_valid ? mix : '0;
      lo_phase  = p_q;
      in_ready  = ~pend_valid_q;
      underrun  = underrun_q;
   end

endmodule

// File: tb/tb_iq_mod.sv
// Bench for iq_mod: period-level behavioural model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_iq_mod;

   localparam int unsigned W   = 8;
   localparam int unsigned DIV = 5;
   localparam int          PER = 4 * DIV;

   logic                clk = 1'b0;
   logic                resetn = 1'b0;
   logic                enable = 1'b0;
   logic                in_valid = 1'b0;
   logic signed [W-1:0] in_i = '0;
   logic signed [W-1:0] in_q = '0;
   logic                in_ready, out_valid, underrun;
   logic signed [W:0]   out_data;
   logic [1:0]          lo_phase;

   always #5 clk = ~clk;

   iq_mod #(.W(W), .DIV(DIV)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .enable    (enable),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_i      (in_i),
      .in_q      (in_q),
      .out_valid (out_valid),
      .out_data  (out_data),
      .lo_phase  (lo_phase),
      .underrun  (underrun)
   );

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic signed [31:0] act, input int expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   // Model: m_t is the cycle index inside the current carrier period.
   bit m_run = 0, m_drain = 0, m_cv = 0, m_pv = 0, m_under = 0;
   int m_t = 0, m_ci = 0, m_cq = 0, m_pi = 0, m_pq = 0;

   task automatic model_step();
      bit acc;
      if (!resetn) begin
         m_run = 0; m_drain = 0; m_cv = 0; m_pv = 0; m_under = 0;
         m_t = 0; m_ci = 0; m_cq = 0;
         return;
      end
      acc     = in_valid && !m_pv;
      m_under = 0;
      if (m_drain) begin
         m_drain = 0;
      end else if (!m_run) begin
         if (enable && m_pv) begin
            m_run = 1; m_t = 0; m_cv = 1; m_ci = m_pi; m_cq = m_pq; m_pv = 0;
         end
      end else if (m_t == PER - 1) begin
         m_t = 0;
         if (!enable) begin
            m_run = 0; m_drain = 1; m_cv = 0;
         end else if (m_pv) begin
            m_cv = 1; m_ci = m_pi; m_cq = m_pq; m_pv = 0;
         end else begin
            m_cv = 0; m_under = 1;
         end
      end else begin
         m_t++;
      end
      if (acc) begin
         m_pv = 1; m_pi = int'(in_i); m_pq = int'(in_q);
      end
   endtask

   initial forever begin
      @(posedge clk or negedge resetn);
      model_step();
   end

   task automatic compare();
      int ph, ed;
      ph = m_run ? m_t / DIV : 0;
      ed = 0;
      if (m_run && m_cv) begin
         case (ph)
            0:       ed = m_ci;
            1:       ed = -m_cq;
            2:       ed = -m_ci;
            default: ed = m_cq;
         endcase
      end
      check("in_ready", in_ready, int'(!m_pv));
      check("out_valid", out_valid, int'(m_run && m_cv));
      check("out_data", out_data, ed);
      check("lo_phase", lo_phase, ph);
      check("underrun", underrun, int'(m_under));
   endtask

   initial forever begin
      @(negedge clk);
      if (chk_en) compare();
   end

   // Stream monitor
   bit mon_en = 0;
   int n_ov = 0, n_un = 0, mcyc = 0, first_v = -1, last_v = -1;
   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         if (out_valid) begin
            n_ov++;
            if (first_v < 0) first_v = mcyc;
            last_v = mcyc;
         end
         if (underrun) n_un++;
         mcyc++;
      end
   end

   // Offer a sample; returns at the negedge after the accepting edge.
   task automatic send(input int i, input int q, input bit keep);
      in_valid = 1'b1;
      in_i     = W'(i);
      in_q     = W'(q);
      for (int n = 0; n < 200; n++) begin
         if (in_ready) break;
         @(negedge clk);
      end
      check("send_ready", in_ready, 1);
      @(negedge clk);
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic wait_valid();
      for (int n = 0; n < 200; n++) begin
         if (out_valid) break;
         @(negedge clk);
      end
      check("wait_valid", out_valid, 1);
   endtask

   int bx[4] = '{37, 12, -37, -12};
   int ex[4] = '{-128, 128, 128, -128};
   int si[4] = '{1, -5, 127, -1};
   int sq[4] = '{2, 100, -128, 0};

   initial begin
      @(negedge clk);
      chk_en = 1'b1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_lo_phase", lo_phase, 0);
      check("rst_underrun", underrun, 0);
      resetn = 1'b1;

      // Basic mix: I = 37, Q = -12
      enable = 1'b1;
      send(37, -12, 1'b0);
      @(negedge clk);
      for (int j = 0; j < PER; j++) begin
         check("basic_data", out_data, bx[j / DIV]);
         check("basic_phase", lo_phase, j / DIV);
         @(negedge clk);
      end
      check("basic_underrun", underrun, 1);
      check("basic_idle_valid", out_valid, 0);

      // Extremes: no wrap in the 9-bit result
      send(-128, -128, 1'b0);
      wait_valid();
      for (int j = 0; j < PER; j++) begin
         check("extreme_data", out_data, ex[j / DIV]);
         @(negedge clk);
      end

      // Back to IDLE, then a back-to-back stream with in_valid held high
      enable = 1'b0;
      repeat (2 * PER) @(negedge clk);
      check("drained_valid", out_valid, 0);
      check("drained_phase", lo_phase, 0);
      mon_en = 1'b1;
      enable = 1'b1;
      for (int s = 0; s < 4; s++) send(si[s], sq[s], 1'b1);
      in_valid = 1'b0;
      repeat (45) @(negedge clk);
      mon_en = 1'b0;
      check("stream_valid_cycles", n_ov, 80);
      check("stream_contiguous", last_v - first_v + 1, 80);
      check("stream_underruns", n_un, 1);

      // Boundary race: sample accepted on the boundary edge waits one period
      for (int n = 0; n < 200; n++) begin
         if (m_run && m_t == PER - 1) break;
         @(negedge clk);
      end
      check("race_sync_phase", lo_phase, 3);
      in_valid = 1'b1;
      in_i     = 8'sd55;
      in_q     = -8'sd7;
      @(negedge clk);
      in_valid = 1'b0;
      check("race_underrun", underrun, 1);
      check("race_valid", out_valid, 0);
      check("race_pend_full", in_ready, 0);
      repeat (PER) @(negedge clk);
      check("race_late_valid", out_valid, 1);
      check("race_late_data", out_data, 55);

      // Disable at p = 1, cnt = 2 with a sample waiting in pend
      send(-20, 33, 1'b0);
      for (int n = 0; n < 200; n++) begin
         if (m_run && m_t == DIV + 2) break;
         @(negedge clk);
      end
      check("dis_phase", lo_phase, 1);
      enable = 1'b0;
      for (int j = DIV + 2; j < PER; j++) begin
         check("dis_tail_valid", out_valid, 1);
         @(negedge clk);
      end
      check("dis_after_valid", out_valid, 0);
      check("dis_after_data", out_data, 0);
      check("dis_after_phase", lo_phase, 0);
      check("dis_pend_kept", in_ready, 0);
      repeat (5) @(negedge clk);
      check("dis_idle_valid", out_valid, 0);
      check("dis_idle_pend", in_ready, 0);
      enable = 1'b1;
      @(negedge clk);
      check("resume_data", out_data, -20);
      repeat (DIV) @(negedge clk);
      check("resume_data_p1", out_data, -33);

      // Asynchronous reset mid-RUN
      #2 resetn = 1'b0;
      #1;
      check("arst_in_ready", in_ready, 1);
      check("arst_out_valid", out_valid, 0);
      check("arst_out_data", out_data, 0);
      check("arst_lo_phase", lo_phase, 0);
      check("arst_underrun", underrun, 0);
      repeat (2) @(negedge clk);
      #2 resetn = 1'b1;
      repeat (10) @(negedge clk);
      check("post_rst_idle_valid", out_valid, 0);
      check("post_rst_idle_phase", lo_phase, 0);
      send(9, 9, 1'b0);
      wait_valid();
      check("post_rst_data", out_data, 9);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
